// File: rtl/pong_pkg.sv
// Shared pong definitions: serve sequencer states, score width and the default win score.
package pong_pkg;

   localparam int unsigned SCORE_W   = 9;
   localparam int unsigned MAX_SCORE = 10;

   typedef enum logic [2:0] {
      StIdle,
      StServeWait,
      StRally,
      StPoint,
      StDone
   } serve_state_t;

   // Increment that never passes the limit; a score already at the limit stays put.
   function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] v,
                                                        input logic [SCORE_W-1:0] lim);
      return (v >= lim) ? v : v + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/frame_delay_counter.sv
// Loadable down-counter advanced by the frame tick; the zero flag marks the end of the delay.
module frame_delay_counter #(
   parameter int unsigned Width = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             i_load,
   input  logic [Width-1:0] i_load_val,
   input  logic             i_tick,
   output logic             o_zero
);

   logic [Width-1:0] r_count;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - Width'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/score_serve_ctrl.sv
// Point scoring and serve sequencing for pong: holds the ball between points, launches serves
// after a frame-counted delay, tracks scores and rally length.
module score_serve_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned MaxScore   = MAX_SCORE,
   parameter int unsigned ServeDelay = 60,
   parameter int unsigned RallyMax   = 255
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               valid,
   input  logic               miss_left,
   input  logic               miss_right,
   input  logic               paddle_hit,
   output logic [SCORE_W-1:0] score_1,
   output logic [SCORE_W-1:0] score_2,
   output logic               ball_hold,
   output logic               serve,
   output logic               serve_dir,
   output logic [7:0]         rally_len
);

   localparam int unsigned        CntW      = (ServeDelay < 2) ? 1 : $clog2(ServeDelay + 1);
   localparam logic [CntW-1:0]    DelayInit = CntW'(ServeDelay);
   localparam logic [SCORE_W-1:0] MaxScoreW = SCORE_W'(MaxScore);
   localparam logic [7:0]         RallyMaxW = 8'(RallyMax);

   serve_state_t       r_state, w_state_next;
   logic               r_valid_prev;
   logic [SCORE_W-1:0] r_score_1, w_score_1_next;
   logic [SCORE_W-1:0] r_score_2, w_score_2_next;
   logic [7:0]         r_rally_len, w_rally_len_next;
   logic               r_ball_hold, w_ball_hold_next;
   logic               r_serve, w_serve_next;
   logic               r_serve_dir, w_serve_dir_next;
   logic               w_cnt_load, w_cnt_tick, w_cnt_zero;

   frame_delay_counter #(
      .Width (CntW)
   ) u_delay (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_load     (w_cnt_load),
      .i_load_val (DelayInit),
      .i_tick     (w_cnt_tick),
      .o_zero     (w_cnt_zero)
   );

   always_comb begin
      w_state_next     = r_state;
      w_score_1_next   = r_score_1;
      w_score_2_next   = r_score_2;
      w_rally_len_next = r_rally_len;
      w_serve_dir_next = r_serve_dir;
      w_serve_next     = 1'b0;
      w_cnt_load       = 1'b0;
      w_cnt_tick       = 1'b0;

      // Losing valid aborts any game phase; scores are kept for the win screen.
      if ((r_state != StIdle) && !valid) begin
         w_state_next = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (valid && !r_valid_prev) begin
                  w_score_1_next   = '0;
                  w_score_2_next   = '0;
                  w_rally_len_next = '0;
                  w_serve_dir_next = 1'b1;
                  w_cnt_load       = 1'b1;
                  w_state_next     = StServeWait;
               end
            end
            StServeWait: begin
               w_cnt_tick = frame_tick;
               if (frame_tick && w_cnt_zero) begin
                  w_serve_next     = 1'b1;
                  w_rally_len_next = '0;
                  w_state_next     = StRally;
               end
            end
            StRally: begin
               // A miss outranks a simultaneous paddle hit; both misses together is a let.
               if (miss_left && miss_right) begin
                  w_state_next = StPoint;
               end else if (miss_right) begin
                  w_score_1_next   = score_sat_inc(r_score_1, MaxScoreW);
                  w_serve_dir_next = 1'b1;
                  w_state_next     = StPoint;
               end else if (miss_left) begin
                  w_score_2_next   = score_sat_inc(r_score_2, MaxScoreW);
                  w_serve_dir_next = 1'b0;
                  w_state_next     = StPoint;
               end else if (paddle_hit && (r_rally_len < RallyMaxW)) begin
                  w_rally_len_next = r_rally_len + 8'd1;
               end
            end
            StPoint: begin
               if ((r_score_1 == MaxScoreW) || (r_score_2 == MaxScoreW)) begin
                  w_state_next = StDone;
               end else begin
                  w_cnt_load   = 1'b1;
                  w_state_next = StServeWait;
               end
            end
            StDone: begin
            end
            default: begin
               w_state_next = StIdle;
            end
         endcase
      end

      w_ball_hold_next = (w_state_next != StRally);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= StIdle;
         r_valid_prev <= 1'b0;
         r_score_1    <= '0;
         r_score_2    <= '0;
         r_rally_len  <= '0;
         r_ball_hold  <= 1'b1;
         r_serve      <= 1'b0;
         r_serve_dir  <= 1'b1;
      end else begin
         r_state      <= w_state_next;
         r_valid_prev <= valid;
         r_score_1    <= w_score_1_next;
         r_score_2    <= w_score_2_next;
         r_rally_len  <= w_rally_len_next;
         r_ball_hold  <= w_ball_hold_next;
         r_serve      <= w_serve_next;
         r_serve_dir  <= w_serve_dir_next;
      end
   end

   assign score_1   = r_score_1;
   assign score_2   = r_score_2;
   assign rally_len = r_rally_len;
   assign ball_hold = r_ball_hold;
   assign serve     = r_serve;
   assign serve_dir = r_serve_dir;

endmodule

// File: tb/tb_score_serve_ctrl.sv
// Randomized bench for score_serve_ctrl with a game-rules reference model and directed scenarios.
module tb_score_serve_ctrl;

   localparam int SD = 3;
   localparam int MS = 10;
   localparam int RM = 255;

   localparam int PH_IDLE  = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_RALLY = 2;
   localparam int PH_POINT = 3;
   localparam int PH_DONE  = 4;

   logic       Clk, Reset;
   logic       frame_tick, valid, miss_left, miss_right, paddle_hit;
   logic [8:0] score_1, score_2;
   logic       ball_hold, serve, serve_dir;
   logic [7:0] rally_len;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 0;

   // Reference model: game phase, ticks still to wait, and the expected visible outputs.
   int m_ph, m_left, m_s1, m_s2, m_rally;
   bit m_prev, m_hold, m_serve, m_dir;

   score_serve_ctrl #(
      .MaxScore   (MS),
      .ServeDelay (SD),
      .RallyMax   (RM)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .valid      (valid),
      .miss_left  (miss_left),
      .miss_right (miss_right),
      .paddle_hit (paddle_hit),
      .score_1    (score_1),
      .score_2    (score_2),
      .ball_hold  (ball_hold),
      .serve      (serve),
      .serve_dir  (serve_dir),
      .rally_len  (rally_len)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic model_reset();
      m_ph = PH_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0; m_rally = 0;
      m_prev = 0; m_hold = 1; m_serve = 0; m_dir = 1;
   endtask

   task automatic model_step();
      bit rise;
      if (!Reset) begin
         model_reset();
         return;
      end
      rise    = valid && !m_prev;
      m_serve = 0;
      if (m_ph != PH_IDLE && !valid) begin
         m_ph = PH_IDLE;
      end else begin
         case (m_ph)
            PH_IDLE: if (rise) begin
               m_s1 = 0; m_s2 = 0; m_rally = 0; m_dir = 1; m_left = SD; m_ph = PH_WAIT;
            end
            PH_WAIT: if (frame_tick) begin
               if (m_left == 0) begin
                  m_serve = 1; m_rally = 0; m_ph = PH_RALLY;
               end else begin
                  m_left = m_left - 1;
               end
            end
            PH_RALLY: begin
               if (miss_left && miss_right) begin
                  m_ph = PH_POINT;
               end else if (miss_right) begin
                  if (m_s1 < MS) m_s1 = m_s1 + 1;
                  m_dir = 1; m_ph = PH_POINT;
               end else if (miss_left) begin
                  if (m_s2 < MS) m_s2 = m_s2 + 1;
                  m_dir = 0; m_ph = PH_POINT;
               end else if (paddle_hit && m_rally < RM) begin
                  m_rally = m_rally + 1;
               end
            end
            PH_POINT: begin
               if (m_s1 == MS || m_s2 == MS) m_ph = PH_DONE;
               else begin
                  m_left = SD; m_ph = PH_WAIT;
               end
            end
            default: ;
         endcase
      end
      m_prev = valid;
      m_hold = (m_ph != PH_RALLY);
   endtask

   task automatic step();
      @(posedge Clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (cmp_en) begin
         n_tests++;
         if (int'(score_1) != m_s1 || int'(score_2) != m_s2 || int'(rally_len) != m_rally ||
             ball_hold !== m_hold || serve !== m_serve || serve_dir !== m_dir) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t got s1=%0d s2=%0d rally=%0d hold=%0b serve=%0b dir=%0b want s1=%0d s2=%0d rally=%0d hold=%0b serve=%0b dir=%0b",
                     $time, score_1, score_2, rally_len, ball_hold, serve, serve_dir,
                     m_s1, m_s2, m_rally, m_hold, m_serve, m_dir);
         end
      end
   end

   task automatic clear_inputs();
      frame_tick = 0; paddle_hit = 0; miss_left = 0; miss_right = 0;
   endtask

   // Bounded wait for the next serve; counts the frame ticks spent waiting.
   task automatic wait_serve(input bit every_other, output int ticks);
      bit ok;
      ticks = 0;
      ok    = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         clear_inputs();
         frame_tick = every_other ? (i % 2 == 0) : 1'($urandom_range(0, 1));
         step();
         if (frame_tick) ticks++;
         if (serve) ok = 1;
      end
      clear_inputs();
      chk("serve_within_bound", int'(ok), 1);
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) begin
         paddle_hit = 1; step();
         paddle_hit = 0; step();
      end
   endtask

   initial begin
      int ticks, serves, points, miss_len, miss_kind, vdrop;
      Reset = 0; valid = 0;
      clear_inputs();
      model_reset();
      cmp_en = 1;
      repeat (3) step();
      Reset = 1;
      step();
      chk("reset_score_1", int'(score_1), 0);
      chk("reset_score_2", int'(score_2), 0);
      chk("reset_ball_hold", int'(ball_hold), 1);
      chk("reset_serve_dir", int'(serve_dir), 1);

      // Game start: serve lands on the 4th tick with ServeDelay=3.
      valid = 1; step();
      chk("wait_ball_hold", int'(ball_hold), 1);
      wait_serve(1, ticks);
      chk("first_serve_ticks", ticks, SD + 1);
      chk("rally_ball_hold", int'(ball_hold), 0);
      step();
      chk("serve_one_cycle", int'(serve), 0);

      // Three hits, then a long miss_right level scores exactly once.
      hits(3);
      miss_right = 1; repeat (5) step(); miss_right = 0;
      chk("rally_len_3", int'(rally_len), 3);
      chk("score_1_once", int'(score_1), 1);
      chk("dir_after_p1_point", int'(serve_dir), 1);
      wait_serve(1, ticks);
      chk("next_serve_ticks", ticks, SD + 1);

      // P2 point flips serve_dir, then a let leaves everything alone.
      miss_left = 1; step(); miss_left = 0; step();
      chk("score_2_one", int'(score_2), 1);
      chk("dir_after_p2_point", int'(serve_dir), 0);
      wait_serve(1, ticks);
      miss_left = 1; miss_right = 1; step(); clear_inputs(); step();
      chk("let_score_1", int'(score_1), 1);
      chk("let_score_2", int'(score_2), 1);
      chk("let_dir", int'(serve_dir), 0);
      wait_serve(1, ticks);
      chk("let_serve_ticks", ticks, SD + 1);

      // Play P2 up to the win score.
      points = 0;
      for (int p = 0; p < 12 && int'(score_2) != MS; p++) begin
         if (p > 0) wait_serve(0, ticks);
         miss_left = 1; step(); miss_left = 0; step();
         points++;
      end
      chk("points_to_win", points, MS - 1);
      chk("score_2_max", int'(score_2), MS);
      serves = 0;
      for (int i = 0; i < 30; i++) begin
         frame_tick = 1; step();
         if (serve) serves++;
      end
      frame_tick = 0;
      chk("no_serve_in_done", serves, 0);
      valid = 0; step(); step();
      chk("idle_keeps_score_2", int'(score_2), MS);
      valid = 1; step();
      chk("restart_score_1", int'(score_1), 0);
      chk("restart_score_2", int'(score_2), 0);

      // Rally length saturation.
      wait_serve(0, ticks);
      hits(300);
      chk("rally_saturates", int'(rally_len), RM);

      // Randomized play checked against the model every cycle.
      miss_len = 0; miss_kind = 0; vdrop = 0;
      for (int c = 0; c < 4000; c++) begin
         frame_tick = ($urandom_range(0, 3) == 0);
         paddle_hit = ($urandom_range(0, 2) == 0);
         if (miss_len == 0 && $urandom_range(0, 24) == 0) begin
            miss_len  = $urandom_range(1, 6);
            miss_kind = $urandom_range(0, 4);
         end
         miss_left  = (miss_len > 0) && (miss_kind < 2 || miss_kind == 4);
         miss_right = (miss_len > 0) && (miss_kind >= 2);
         if (miss_len > 0) miss_len--;
         if (vdrop == 0 && $urandom_range(0, 149) == 0) vdrop = $urandom_range(1, 4);
         valid = (vdrop == 0);
         if (vdrop > 0) vdrop--;
         step();
      end
      clear_inputs();

      // Asynchronous reset in the middle of a rally.
      valid = 0; step();
      valid = 1; step();
      wait_serve(0, ticks);
      hits(2);
      Reset = 0;
      model_reset();
      #1;
      chk("async_rst_score_1", int'(score_1), 0);
      chk("async_rst_ball_hold", int'(ball_hold), 1);
      chk("async_rst_serve", int'(serve), 0);
      chk("async_rst_dir", int'(serve_dir), 1);
      chk("async_rst_rally", int'(rally_len), 0);
      step(); step();
      valid = 0;
      Reset = 1;
      serves = 0;
      for (int i = 0; i < 10; i++) begin
         frame_tick = 1; step();
         if (serve || !ball_hold) serves++;
      end
      chk("stay_idle_after_reset", serves, 0);

      cmp_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
